// File: rtl/core_port_edge.sv
// core_port_edge: synchronised, optionally debounced input port with per-pin edge interrupt flags.
// Optional debounce filter enabled by defining CORE_PORT_EDGE_DEBOUNCE_EN.
module core_port_edge #(
  parameter int WIDTH        = 8,
  parameter int DEBOUNCE_DIV = 16,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic [WIDTH-1:0] pin_i,
  input  logic [WIDTH-1:0] ddr_i,
  input  logic [WIDTH-1:0] imr_i,
  input  logic [WIDTH-1:0] edge_sel_i,
  input  logic [WIDTH-1:0] ifr_clr_i,
  output logic [WIDTH-1:0] pin_o,
  output logic [WIDTH-1:0] ifr_o,
  output logic             irq_o
);

  if (DEBOUNCE_DIV < 2 || DEBOUNCE_DIV > 65535 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : g_bad_cfg
    $error("core_port_edge: debounce parameters out of range");
  end

  logic [WIDTH-1:0] r_sync1, r_sync2, r_stable, r_prev, r_ifr;
  logic [WIDTH-1:0] w_stable_nxt, w_rise, w_fall, w_set;
  logic [1:0]       r_arm_cnt;
  logic             w_arm, w_load, w_live;

  // arm goes high on the 2nd edge after reset; the load happens in that first armed cycle,
  // so the synchroniser has already been filled with the real pin levels
  assign w_arm  = r_arm_cnt[1];
  assign w_load = (r_arm_cnt == 2'd2);
  assign w_live = (r_arm_cnt == 2'd3);

  // two-flop synchroniser for the asynchronous pins
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pin_i;
      r_sync2 <= r_sync1;
    end
  end

  // arm sequencer, saturates once the stable level has been loaded
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)
      r_arm_cnt <= 2'd0;
    else if (!w_live)
      r_arm_cnt <= r_arm_cnt + 2'd1;
  end

`ifdef CORE_PORT_EDGE_DEBOUNCE_EN
  logic [15:0] r_div;
  logic        w_tick;
  logic [3:0]  r_cnt [WIDTH];
  logic [3:0]  w_cnt_nxt [WIDTH];

  assign w_tick = (r_div == 16'(DEBOUNCE_DIV - 1));

  // free-running prescaler producing one tick per DEBOUNCE_DIV cycles
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)
      r_div <= '0;
    else
      r_div <= w_tick ? 16'd0 : r_div + 16'd1;
  end

  // per-pin filter: a new level is accepted only after DEBOUNCE_CNT ticks of disagreement
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = 4'd0;
      if (r_sync2[i] != r_stable[i]) begin
        if (!w_tick)
          w_cnt_nxt[i] = r_cnt[i];
        else if (r_cnt[i] == 4'(DEBOUNCE_CNT - 1))
          w_stable_nxt[i] = r_sync2[i];
        else
          w_cnt_nxt[i] = r_cnt[i] + 4'd1;
      end
    end
  end

  // debounce counters only run once the stable level is established
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= 4'd0;
    end else if (w_live) begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end
`else
  assign w_stable_nxt = r_sync2;
`endif

  // stable level and previous level; initial load produces no edge
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_stable <= '0;
      r_prev   <= '0;
    end else if (w_load) begin
      r_stable <= r_sync2;
      r_prev   <= r_sync2;
    end else if (w_live) begin
      r_stable <= w_stable_nxt;
      r_prev   <= r_stable;
    end
  end

  assign w_rise = ~r_prev & r_stable;
  assign w_fall = r_prev & ~r_stable;
  assign w_set  = ((w_rise & ~edge_sel_i) | (w_fall & edge_sel_i)) & imr_i & ~ddr_i & {WIDTH{w_arm & w_live}};

  // interrupt flags: write-1-to-clear, a simultaneous new edge wins
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)
      r_ifr <= '0;
    else
      r_ifr <= (r_ifr & ~ifr_clr_i) | w_set;
  end

  assign pin_o = r_stable;
  assign ifr_o = r_ifr;
  assign irq_o = |r_ifr;

endmodule
